// File: rtl/decode_cycle.sv
// decode_cycle: RV32I-subset decode stage with a 32x32 register file and ID/EX pipeline register.
// Define REGFILE_BYPASS_EN to make register-file reads write-first against the same-cycle writeback.
module decode_cycle #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           InstrD,
    input  logic [31:0]           PCD,
    input  logic [31:0]           PCPlus4D,
    input  logic                  FlushE,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [31:0]           ResultW,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  BranchE,
    output logic                  JumpE,
    output logic                  ALUSrcE,
    output logic [1:0]            ResultSrcE,
    output logic [2:0]            ALUControlE,
    output logic [31:0]           RD1E,
    output logic [31:0]           RD2E,
    output logic [31:0]           ImmExtE,
    output logic [31:0]           PCE,
    output logic [31:0]           PCPlus4E,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic [REG_ADDR_W-1:0] Rs1D,
    output logic [REG_ADDR_W-1:0] Rs2D
);
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src;
        logic [1:0]            result_src;
        logic [2:0]            alu_control;
        logic [31:0]           rd1;
        logic [31:0]           rd2;
        logic [31:0]           imm;
        logic [31:0]           pc;
        logic [31:0]           pc_plus4;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_t;

    id_ex_t d, e;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] alu_op;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, rd1, rd2;
    logic [31:0] rf [2**REG_ADDR_W];

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[15 +: REG_ADDR_W];
    assign Rs2D   = InstrD[20 +: REG_ADDR_W];

    assign imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
    assign imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_j = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    // funct7b5 selects sub only for register-register ops; addi with imm[10]=1 stays add
    assign alu_op = funct3 == 3'b000 ? ((opcode == 7'b0110011 && InstrD[30]) ? 3'b001 : 3'b000) :
                    funct3 == 3'b010 ? 3'b101 :
                    funct3 == 3'b110 ? 3'b011 :
                    funct3 == 3'b111 ? 3'b010 : 3'b000;

`ifdef REGFILE_BYPASS_EN
    assign rd1 = Rs1D == '0 ? '0 : (RegWriteW && RdW == Rs1D) ? ResultW : rf[Rs1D];
    assign rd2 = Rs2D == '0 ? '0 : (RegWriteW && RdW == Rs2D) ? ResultW : rf[Rs2D];
`else
    assign rd1 = Rs1D == '0 ? '0 : rf[Rs1D];
    assign rd2 = Rs2D == '0 ? '0 : rf[Rs2D];
`endif

    always_comb begin
        d          = '0;
        d.rd1      = rd1;
        d.rd2      = rd2;
        d.pc       = PCD;
        d.pc_plus4 = PCPlus4D;
        d.rs1      = Rs1D;
        d.rs2      = Rs2D;
        d.rd       = InstrD[7 +: REG_ADDR_W];
        case (opcode)
            7'b0000011: begin
                d.reg_write  = 1'b1;
                d.alu_src    = 1'b1;
                d.result_src = 2'b01;
                d.imm        = imm_i;
            end
            7'b0100011: begin
                d.mem_write = 1'b1;
                d.alu_src   = 1'b1;
                d.imm       = imm_s;
            end
            7'b0110011: begin
                d.reg_write   = 1'b1;
                d.alu_control = alu_op;
            end
            7'b0010011: begin
                d.reg_write   = 1'b1;
                d.alu_src     = 1'b1;
                d.alu_control = alu_op;
                d.imm         = imm_i;
            end
            7'b1100011: begin
                d.branch      = 1'b1;
                d.alu_control = 3'b001;
                d.imm         = imm_b;
            end
            7'b1101111: begin
                d.reg_write  = 1'b1;
                d.jump       = 1'b1;
                d.result_src = 2'b10;
                d.imm        = imm_j;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            rf <= '{default: '0};
        else if (RegWriteW && RdW != '0)
            rf[RdW] <= ResultW;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            e <= '0;
        else
            e <= FlushE ? '0 : d;

    assign RegWriteE   = e.reg_write;
    assign MemWriteE   = e.mem_write;
    assign BranchE     = e.branch;
    assign JumpE       = e.jump;
    assign ALUSrcE     = e.alu_src;
    assign ResultSrcE  = e.result_src;
    assign ALUControlE = e.alu_control;
    assign RD1E        = e.rd1;
    assign RD2E        = e.rd2;
    assign ImmExtE     = e.imm;
    assign PCE         = e.pc;
    assign PCPlus4E    = e.pc_plus4;
    assign Rs1E        = e.rs1;
    assign Rs2E        = e.rs2;
    assign RdE         = e.rd;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: vector table plus hand sequences for writeback, flush and async reset.
module tb_decode_cycle;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
    logic        FlushE = 1'b0, RegWriteW = 1'b0;
    logic [4:0]  RdW = '0;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE, Rs1D, Rs2D;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D)
    );

    always #5 clk = ~clk;

    // ctrl = {RegWrite, MemWrite, Branch, Jump, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
    typedef struct packed {
        logic [9:0]  ctrl;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  r1, r2, rd;
    } eout_t;

    typedef struct {
        logic [31:0] instr;
        logic        flush;
        logic [9:0]  ctrl;
        logic [31:0] imm;
    } vec_t;

    localparam logic [9:0] C_ADDI = 10'b10001_00_000;
    localparam logic [9:0] C_R    = 10'b10000_00_000;

    eout_t       exp_q[$];
    eout_t       act;
    logic [31:0] m [32];
    vec_t        v [16];
    int          tests = 0, fails = 0;

    assign act = {RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE,
                  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};

    task automatic check(input string name, input logic [255:0] a, input logic [255:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, a, x);
        end
    endtask

    // drive one decode cycle at negedge, expect the E outputs one edge later
    task automatic step(input string name, input logic [31:0] instr, input logic flush,
                        input logic [9:0] ctrl, input logic [31:0] imm,
                        input logic we, input logic [4:0] rdw, input logic [31:0] resw);
        eout_t      x;
        logic [4:0] r1, r2;
        r1 = instr[19:15];
        r2 = instr[24:20];
        InstrD = instr; FlushE = flush; RegWriteW = we; RdW = rdw; ResultW = resw;
        PCD = $urandom; PCPlus4D = PCD + 32'd4;
        x.ctrl = ctrl; x.imm = imm; x.pc = PCD; x.pc4 = PCPlus4D;
        x.r1 = r1; x.r2 = r2; x.rd = instr[11:7];
        x.rd1 = m[r1]; x.rd2 = m[r2];
`ifdef REGFILE_BYPASS_EN
        if (we && rdw != 5'd0 && rdw == r1) x.rd1 = resw;
        if (we && rdw != 5'd0 && rdw == r2) x.rd2 = resw;
`endif
        if (flush) x = '0;
        exp_q.push_back(x);
        #1 check({name, "_rsD"}, 256'({Rs1D, Rs2D}), 256'({r1, r2}));
        @(posedge clk);
        if (we && rdw != 5'd0) m[rdw] = resw;
        #1 check(name, 256'(act), 256'(exp_q.pop_front()));
        RegWriteW = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m[i] = '0;
        v[0]  = '{32'h00500093, 1'b0, C_ADDI,          32'h00000005};
        v[1]  = '{32'hFE208CE3, 1'b0, 10'b00100_00_001, 32'hFFFFFFF8};
        v[2]  = '{32'hFE208CE3, 1'b1, 10'b00100_00_001, 32'hFFFFFFF8};
        v[3]  = '{32'h00512623, 1'b0, 10'b01001_00_000, 32'h0000000C};
        v[4]  = '{32'hFFC12183, 1'b0, 10'b10001_01_000, 32'hFFFFFFFC};
        v[5]  = '{32'h00208233, 1'b0, C_R,             32'h0};
        v[6]  = '{32'h40208233, 1'b0, 10'b10000_00_001, 32'h0};
        v[7]  = '{32'h40008213, 1'b0, C_ADDI,          32'h00000400};
        v[8]  = '{32'h0020A233, 1'b0, 10'b10000_00_101, 32'h0};
        v[9]  = '{32'hFFF0E213, 1'b0, 10'b10001_00_011, 32'hFFFFFFFF};
        v[10] = '{32'h0020F233, 1'b0, 10'b10000_00_010, 32'h0};
        v[11] = '{32'h0020C233, 1'b0, C_R,             32'h0};
        v[12] = '{32'h008000EF, 1'b0, 10'b10010_10_000, 32'h00000008};
        v[13] = '{32'hFFDFF0EF, 1'b0, 10'b10010_10_000, 32'hFFFFFFFC};
        v[14] = '{32'hFFFFFFFF, 1'b0, 10'b0,           32'h0};
        v[15] = '{32'h00512623, 1'b1, 10'b01001_00_000, 32'h0000000C};

        InstrD = 32'h00500093;
        repeat (2) @(posedge clk);
        #1 check("reset", 256'(act), 256'(0));
        @(negedge clk) rst = 1'b0;
        step("rd_x1_after_reset", 32'h00208233, 1'b0, C_R, 32'h0, 1'b0, 5'd0, 32'h0);

        step("wb_x1", 32'h0, 1'b0, 10'b0, 32'h0, 1'b1, 5'd1, 32'h11111111);
        step("wb_x2", 32'h0, 1'b0, 10'b0, 32'h0, 1'b1, 5'd2, 32'h22222222);
        step("wb_x5", 32'h0, 1'b0, 10'b0, 32'h0, 1'b1, 5'd5, 32'h55555555);

        for (int i = 0; i < 16; i++)
            step($sformatf("vec%0d", i), v[i].instr, v[i].flush, v[i].ctrl, v[i].imm, 1'b0, 5'd0, 32'h0);

        step("wb_same_cycle_x3", 32'h00018293, 1'b0, C_ADDI, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF);
        step("rd_x3", 32'h00018293, 1'b0, C_ADDI, 32'h0, 1'b0, 5'd0, 32'h0);
        step("wb_x0", 32'h0, 1'b0, 10'b0, 32'h0, 1'b1, 5'd0, 32'h00001234);
        step("rd_x0", 32'h00000293, 1'b0, C_ADDI, 32'h0, 1'b0, 5'd0, 32'h0);
        step("flush_with_wb", 32'h00030293, 1'b1, C_ADDI, 32'h0, 1'b1, 5'd6, 32'hCAFEF00D);
        step("rd_x6", 32'h00030293, 1'b0, C_ADDI, 32'h0, 1'b0, 5'd0, 32'h0);

        // async reset between edges, with a writeback pending that must be dropped
        InstrD = 32'h00038293; RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h0000ABCD;
        #2 rst = 1'b1;
        #1 check("async_rst", 256'(act), 256'(0));
        @(posedge clk);
        #1 check("rst_hold", 256'(act), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        RegWriteW = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = '0;
        step("post_rst_x1_x7", 32'h00708233, 1'b0, C_R, 32'h0, 1'b0, 5'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-index width (32 architectural registers).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 InstrD  input  32  instruction from IF/ID register.
REQ-005 PCD, PCPlus4D  input  32 each  PC and next-sequential PC from IF/ID register.
REQ-006 FlushE  input  1  convert the instruction being latched into a bubble (driven from PCSrcE).
REQ-007 RegWriteW  input  1  writeback enable; RdW input 5 destination index; ResultW input 32 writeback data.
REQ-008 RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  output  1 each  registered control.
REQ-009 ResultSrcE  output  2; ALUControlE  output  3  registered control.
REQ-010 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  32 each  registered datapath.
REQ-011 Rs1E, Rs2E, RdE  output  5 each  registered indices; Rs1D, Rs2D  output  5 each  combinational indices for hazard unit.

Function
REQ-012 Fields: opcode=InstrD[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7b5=[30].
REQ-013 Decode: 0000011 lw -> RegWrite=1, ALUSrc=1, ResultSrc=01, ALU=add; 0100011 sw -> MemWrite=1, ALUSrc=1, ALU=add; 0110011 R -> RegWrite=1; 0010011 I-ALU -> RegWrite=1, ALUSrc=1; 1100011 beq -> Branch=1, ALU=sub; 1101111 jal -> RegWrite=1, Jump=1, ResultSrc=10.
REQ-014 ALUControl for R/I-ALU by funct3: 000 add(000), sub(001) only when R and funct7b5=1; 010 slt(101); 110 or(011); 111 and(010); other funct3 -> add.
REQ-015 Unknown opcode SHALL decode as bubble: all control 0, ImmExt 0.
REQ-016 ImmExt sign-extended from InstrD[31]: I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}; R-type 0.
REQ-017 Register file 32x32, two combinational read ports (rs1, rs2), one write port on rising clk when RegWriteW=1 and RdW!=0.
REQ-018 Register x0 SHALL always read 0; writes to RdW=0 ignored.
REQ-019 ID/EX register SHALL latch all decoded outputs each rising edge; latency InstrD -> E outputs = 1 cycle.
REQ-020 FlushE=1 at edge SHALL latch bubble: all control and all 32-bit/5-bit E outputs 0; flush overrides any valid decode.
REQ-021 Register-file write and ID/EX latch in same cycle both take effect; FlushE does not block a writeback.
REQ-022 Rs1D/Rs2D SHALL equal InstrD[19:15]/[24:20] combinationally, unaffected by FlushE.

Reset
REQ-023 rst=1 SHALL immediately clear every registered output to 0 and all 32 registers to 0, independent of clk.
REQ-024 rst asserted mid-operation SHALL discard pending decode and any same-cycle writeback; first latch after deassertion uses current InstrD.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN defined: read port returns ResultW when RegWriteW=1, RdW!=0 and RdW equals read index (write-first).
REQ-026 REGFILE_BYPASS_EN undefined: read returns pre-write contents in that cycle; hazard unit covers the case.

Verification
REQ-027 Reset: rst=1 with InstrD=0x00500093 -> all E outputs 0, RD1 of x1 = 0.
REQ-028 addi x1,x0,5 (0x00500093) -> next edge RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RdE=1.
REQ-029 beq x1,x2,-8 (0xFE208CE3) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8; same with FlushE=1 -> all outputs 0.
REQ-030 Writeback RdW=3, ResultW=0xDEADBEEF while InstrD reads rs1=3 -> RD1E=0xDEADBEEF with REGFILE_BYPASS_EN, old value (0) without.
REQ-031 Writeback RdW=0, ResultW=0x1234 then read rs1=0 -> RD1E=0.
REQ-032 sw x5,12(x2) (0x00512623) -> MemWriteE=1, RegWriteE=0, ImmExtE=12.
